// File: rtl/spi_console_tx_pkg.sv
// spi_console_tx_pkg
//   Shared definitions for the SPI console transmitter:
//   - CONSOLE_ADDR_DEFAULT : word address of the console MMIO register
//   - CONSOLE_MASK         : the only byte-lane mask that counts as a console write
//   - byte_t               : one console character
//   - spi_state_t          : transmit FSM states
package spi_console_tx_pkg;

  localparam logic [29:0] CONSOLE_ADDR_DEFAULT = 30'h3f800000;
  localparam logic [3:0]  CONSOLE_MASK         = 4'b0001;

  typedef logic [7:0] byte_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOW  = 2'd1,
    HIGH = 2'd2
  } spi_state_t;

endpackage

// File: rtl/spi_console_fifo.sv
// spi_console_fifo
//   Byte FIFO with wrap-bit pointers (log2(DEPTH)+1 bits). Flags are
//   registered from the next-state pointers, so they describe the FIFO
//   after the current cycle's push/pop.
//   The caller guarantees push only when there is room (or a pop in the
//   same cycle) and pop only when non-empty.
// Ports:
//   i_clk, i_rst   clock, synchronous active-high reset (flushes FIFO)
//   i_push, i_data write i_data at the tail
//   i_pop          advance the head
//   o_head         current head entry (valid when !o_empty)
//   o_full         FIFO full (registered)
//   o_empty        FIFO empty (registered)
//   o_empty_nxt    empty state after this cycle's push/pop (combinational)
module spi_console_fifo
  import spi_console_tx_pkg::*;
#(
  parameter int DEPTH = 16
) (
  input  logic  i_clk,
  input  logic  i_rst,
  input  logic  i_push,
  input  byte_t i_data,
  input  logic  i_pop,
  output byte_t o_head,
  output logic  o_full,
  output logic  o_empty,
  output logic  o_empty_nxt
);

  localparam int AW = $clog2(DEPTH);

  byte_t       r_mem [DEPTH];
  logic [AW:0] r_wr;
  logic [AW:0] r_rd;
  logic        r_full;
  logic        r_empty;
  logic [AW:0] w_wr_nxt;
  logic [AW:0] w_rd_nxt;
  logic        w_full_nxt;

  assign w_wr_nxt    = r_wr + (AW+1)'(i_push);
  assign w_rd_nxt    = r_rd + (AW+1)'(i_pop);
  assign w_full_nxt  = (w_wr_nxt[AW] != w_rd_nxt[AW]) &&
                       (w_wr_nxt[AW-1:0] == w_rd_nxt[AW-1:0]);
  assign o_empty_nxt = (w_wr_nxt == w_rd_nxt);

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_wr    <= '0;
      r_rd    <= '0;
      r_full  <= 1'b0;
      r_empty <= 1'b1;
    end else begin
      r_wr    <= w_wr_nxt;
      r_rd    <= w_rd_nxt;
      r_full  <= w_full_nxt;
      r_empty <= o_empty_nxt;
    end
  end

  // On push-while-full with a pop, the tail slot is the head slot; the head
  // is read combinationally this cycle, so overwriting it at the edge is safe.
  always_ff @(posedge i_clk) begin
    if (i_push) begin
      r_mem[r_wr[AW-1:0]] <= i_data;
    end
  end

  assign o_head  = r_mem[r_rd[AW-1:0]];
  assign o_full  = r_full;
  assign o_empty = r_empty;

endmodule

// File: rtl/spi_console_tx.sv
// spi_console_tx
//   Snoops the core data-memory write port for byte writes to the console
//   word, queues them, and shifts them out MSB-first on an SPI mode-0
//   transmit link. Never back-pressures the core: bytes arriving while the
//   FIFO is full are dropped and counted.
//   Optional macro SPI_CONSOLE_SIM_PRINT_EN adds simulation-only printing of
//   each popped character and a warning per dropped byte; no RTL change.
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   IN_MEM_writeEnable  active-low write strobe
//   IN_MEM_writeAddr    word address
//   IN_MEM_writeData    write data (byte in [7:0])
//   IN_MEM_writeMask    byte-lane mask
//   OUT_SPI_clk         serial clock, idle low
//   OUT_SPI_mosi        serial data, changes on falling edge / load
//   OUT_busy            FIFO non-empty or frame in progress (registered)
//   OUT_full            FIFO full (registered)
//   OUT_dropCnt         saturating count of dropped bytes
//
// State | meaning
// IDLE  | no frame; pops head into shifter as soon as FIFO is non-empty
// LOW   | SPI clock low for CLK_DIV cycles, mosi holds current bit
// HIGH  | SPI clock high for CLK_DIV cycles; on exit shift or finish byte
module spi_console_tx
  import spi_console_tx_pkg::*;
#(
  parameter int          FIFO_DEPTH   = 16,
  parameter int          CLK_DIV      = 2,
  parameter logic [29:0] CONSOLE_ADDR = CONSOLE_ADDR_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        IN_MEM_writeEnable,
  input  logic [29:0] IN_MEM_writeAddr,
  input  logic [31:0] IN_MEM_writeData,
  input  logic [3:0]  IN_MEM_writeMask,
  output logic        OUT_SPI_clk,
  output logic        OUT_SPI_mosi,
  output logic        OUT_busy,
  output logic        OUT_full,
  output logic [7:0]  OUT_dropCnt
);

  localparam int               DIV_W    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LOAD = DIV_W'(CLK_DIV - 1);

  spi_state_t       r_state;
  spi_state_t       w_state_nxt;
  logic [DIV_W-1:0] r_div;
  logic [DIV_W-1:0] w_div_nxt;
  byte_t            r_shift;
  byte_t            w_shift_nxt;
  logic [2:0]       r_bit;
  logic [2:0]       w_bit_nxt;
  logic             r_sclk;
  logic             w_sclk_nxt;
  logic             r_mosi;
  logic             w_mosi_nxt;
  logic             r_busy;
  logic [7:0]       r_drop;

  logic             w_accept;
  logic             w_push;
  logic             w_pop;
  logic             w_drop;
  logic             w_div_tc;
  byte_t            w_head;
  logic             w_full;
  logic             w_empty;
  logic             w_empty_nxt;
  logic             w_unused_data;

  assign w_unused_data = ^IN_MEM_writeData[31:8];

  assign w_accept = !IN_MEM_writeEnable &&
                    (IN_MEM_writeAddr == CONSOLE_ADDR) &&
                    (IN_MEM_writeMask == CONSOLE_MASK);
  // A pop in the same cycle frees the slot, so a full FIFO still accepts.
  assign w_push   = w_accept && (!w_full || w_pop);
  assign w_drop   = w_accept && w_full && !w_pop;
  assign w_div_tc = (r_div == '0);

  spi_console_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .i_clk       (clk),
    .i_rst       (rst),
    .i_push      (w_push),
    .i_data      (IN_MEM_writeData[7:0]),
    .i_pop       (w_pop),
    .o_head      (w_head),
    .o_full      (w_full),
    .o_empty     (w_empty),
    .o_empty_nxt (w_empty_nxt)
  );

  always_comb begin
    w_state_nxt = r_state;
    w_div_nxt   = r_div;
    w_shift_nxt = r_shift;
    w_bit_nxt   = r_bit;
    w_sclk_nxt  = r_sclk;
    w_mosi_nxt  = r_mosi;
    w_pop       = 1'b0;
    case (r_state)
      IDLE: begin
        if (!w_empty) begin
          w_pop       = 1'b1;
          w_shift_nxt = w_head;
          w_mosi_nxt  = w_head[7];
          w_bit_nxt   = 3'd0;
          w_div_nxt   = DIV_LOAD;
          w_state_nxt = LOW;
        end
      end
      LOW: begin
        if (w_div_tc) begin
          w_sclk_nxt  = 1'b1;
          w_div_nxt   = DIV_LOAD;
          w_state_nxt = HIGH;
        end else begin
          w_div_nxt = r_div - 1'b1;
        end
      end
      HIGH: begin
        if (w_div_tc) begin
          w_sclk_nxt = 1'b0;
          w_div_nxt  = DIV_LOAD;
          if (r_bit == 3'd7) begin
            w_state_nxt = IDLE;
          end else begin
            w_shift_nxt = {r_shift[6:0], 1'b0};
            w_mosi_nxt  = r_shift[6];
            w_bit_nxt   = r_bit + 1'b1;
            w_state_nxt = LOW;
          end
        end else begin
          w_div_nxt = r_div - 1'b1;
        end
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_div   <= '0;
      r_shift <= '0;
      r_bit   <= '0;
      r_sclk  <= 1'b0;
      r_mosi  <= 1'b0;
      r_busy  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_div   <= w_div_nxt;
      r_shift <= w_shift_nxt;
      r_bit   <= w_bit_nxt;
      r_sclk  <= w_sclk_nxt;
      r_mosi  <= w_mosi_nxt;
      r_busy  <= !w_empty_nxt || (w_state_nxt != IDLE);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_drop <= '0;
    end else if (w_drop && (r_drop != 8'hff)) begin
      r_drop <= r_drop + 8'd1;
    end
  end

`ifdef SPI_CONSOLE_SIM_PRINT_EN
  always @(posedge clk) begin
    if (!rst && w_pop) begin
      $write("%c", w_head);
    end
    if (!rst && w_drop) begin
      $display("spi_console_tx: warning, console byte %02h dropped (FIFO full)",
               IN_MEM_writeData[7:0]);
    end
  end
`endif

  assign OUT_SPI_clk  = r_sclk;
  assign OUT_SPI_mosi = r_mosi;
  assign OUT_busy     = r_busy;
  assign OUT_full     = w_full;
  assign OUT_dropCnt  = r_drop;

endmodule

// File: tb/tb_spi_console_tx.sv
module tb_spi_console_tx;

  localparam logic [29:0] CADDR = 30'h3f800000;

  logic        clk = 1'b0;
  logic        rst;
  logic        we_n;
  logic [29:0] addr;
  logic [31:0] data;
  logic [3:0]  mask;
  logic        spi_clk;
  logic        spi_mosi;
  logic        busy;
  logic        full;
  logic [7:0]  drop_cnt;

  int vectors     = 0;
  int miscompares = 0;
  int cyc         = 0;
  int spi_edges   = 0;
  bit sb_en       = 1'b1;
  logic [7:0] sb_q[$];

  logic [7:0] mon_sh   = '0;
  int         mon_nb   = 0;
  logic       mon_prev = 1'b0;

  spi_console_tx #(
    .FIFO_DEPTH   (16),
    .CLK_DIV      (2),
    .CONSOLE_ADDR (CADDR)
  ) dut (
    .clk                (clk),
    .rst                (rst),
    .IN_MEM_writeEnable (we_n),
    .IN_MEM_writeAddr   (addr),
    .IN_MEM_writeData   (data),
    .IN_MEM_writeMask   (mask),
    .OUT_SPI_clk        (spi_clk),
    .OUT_SPI_mosi       (spi_mosi),
    .OUT_busy           (busy),
    .OUT_full           (full),
    .OUT_dropCnt        (drop_cnt)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // SPI receiver: samples mosi on each rising SPI clock, compares whole bytes
  // against the scoreboard queue.
  always @(negedge clk) begin
    logic [7:0] exp_b;
    if (rst) begin
      mon_nb   = 0;
      mon_prev = 1'b0;
    end else begin
      if (spi_clk && !mon_prev) begin
        spi_edges++;
        mon_sh = {mon_sh[6:0], spi_mosi};
        mon_nb++;
        if (mon_nb == 8) begin
          mon_nb = 0;
          if (sb_en) begin
            if (sb_q.size() > 0) exp_b = sb_q.pop_front();
            else exp_b = 'x;
            check("sb_byte", {24'h0, mon_sh}, {24'h0, exp_b});
          end
        end
      end
      mon_prev = spi_clk;
    end
  end

  task automatic wr(input logic [29:0] a, input logic [31:0] d, input logic [3:0] m);
    we_n = 1'b0;
    addr = a;
    data = d;
    mask = m;
    @(posedge clk);
    #1;
    we_n = 1'b1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(posedge clk);
    #1;
    @(negedge clk);
    #1;
    rst = 1'b0;
    sb_q.delete();
  endtask

  task automatic drain(input string tag);
    int t = 0;
    while ((busy || sb_q.size() != 0) && t < 2000) begin
      @(posedge clk);
      #1;
      t++;
    end
    check(tag, (t < 2000) ? 32'd1 : 32'd0, 32'd1);
  endtask

  initial begin
    int c0;
    int e0;
    logic busy_seen;
    int t;

    rst  = 1'b1;
    we_n = 1'b1;
    addr = '0;
    data = '0;
    mask = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_sclk", {31'h0, spi_clk}, 32'd0);
    check("rst_mosi", {31'h0, spi_mosi}, 32'd0);
    check("rst_busy", {31'h0, busy}, 32'd0);
    check("rst_full", {31'h0, full}, 32'd0);
    check("rst_drop", {24'h0, drop_cnt}, 32'd0);
    @(negedge clk);
    #1;
    rst = 1'b0;

    // single character 'A'
    e0 = spi_edges;
    sb_q.push_back(8'h41);
    wr(CADDR, 32'h00000041, 4'b0001);
    check("a_busy_set", {31'h0, busy}, 32'd1);
    repeat (32) begin @(posedge clk); #1; end
    check("a_busy_32", {31'h0, busy}, 32'd1);
    @(posedge clk);
    #1;
    check("a_busy_33", {31'h0, busy}, 32'd0);
    check("a_edges", spi_edges - e0, 32'd8);
    check("a_sb_empty", sb_q.size(), 32'd0);
    check("a_mosi_hold", {31'h0, spi_mosi}, 32'd1);
    check("a_drop", {24'h0, drop_cnt}, 32'd0);

    // writes that must be ignored
    e0 = spi_edges;
    wr(CADDR, 32'h00000042, 4'b0011);
    wr(CADDR + 30'd1, 32'h00000043, 4'b0001);
    addr = CADDR; mask = 4'b0001; data = 32'h44; we_n = 1'b1;
    busy_seen = 1'b0;
    repeat (50) begin @(posedge clk); #1; busy_seen |= busy; end
    check("ign_busy", {31'h0, busy_seen}, 32'd0);
    check("ign_edges", spi_edges - e0, 32'd0);
    check("ign_drop", {24'h0, drop_cnt}, 32'd0);

    // 20-cycle burst: first byte popped one cycle after its push, the next
    // pop comes 33 cycles after that, so 17 accepted and 3 dropped.
    e0 = spi_edges;
    c0 = 0;
    for (int i = 0; i < 20; i++) begin
      if (i < 17) sb_q.push_back(8'h60 + 8'(i));
      wr(CADDR, 32'hABCD_0060 + 32'(i), 4'b0001);
      if (i == 0) c0 = cyc;
    end
    check("burst_full", {31'h0, full}, 32'd1);
    check("burst_drop", {24'h0, drop_cnt}, 32'd3);
    // push in the same cycle IDLE pops the second byte out of a full FIFO
    while (cyc < c0 + 33) begin @(posedge clk); #1; end
    sb_q.push_back(8'hA5);
    wr(CADDR, 32'h000000A5, 4'b0001);
    check("simul_drop", {24'h0, drop_cnt}, 32'd3);
    check("simul_full", {31'h0, full}, 32'd1);
    drain("burst_drain_timeout");
    check("burst_sb_empty", sb_q.size(), 32'd0);
    check("burst_edges", spi_edges - e0, 32'd144);
    check("burst_full_clr", {31'h0, full}, 32'd0);

    // drop counter saturation
    do_reset();
    sb_en = 1'b0;
    for (int i = 0; i < 300; i++) wr(CADDR, 32'(i), 4'b0001);
    check("sat_drop", {24'h0, drop_cnt}, 32'hff);
    do_reset();
    check("sat_rst_drop", {24'h0, drop_cnt}, 32'd0);
    check("sat_rst_busy", {31'h0, busy}, 32'd0);

    // reset in the middle of a frame with two bytes queued
    e0 = spi_edges;
    wr(CADDR, 32'h31, 4'b0001);
    wr(CADDR, 32'h32, 4'b0001);
    wr(CADDR, 32'h33, 4'b0001);
    t = 0;
    while (spi_edges < e0 + 3 && t < 200) begin @(negedge clk); #1; t++; end
    check("mid_wait_timeout", (t < 200) ? 32'd1 : 32'd0, 32'd1);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("mid_sclk", {31'h0, spi_clk}, 32'd0);
    check("mid_mosi", {31'h0, spi_mosi}, 32'd0);
    check("mid_busy", {31'h0, busy}, 32'd0);
    check("mid_full", {31'h0, full}, 32'd0);
    @(negedge clk);
    #1;
    rst = 1'b0;
    e0 = spi_edges;
    repeat (100) begin @(posedge clk); #1; end
    check("mid_no_edges", spi_edges - e0, 32'd0);
    check("mid_idle_busy", {31'h0, busy}, 32'd0);

    // recovery after reset
    sb_q.delete();
    sb_en = 1'b1;
    sb_q.push_back(8'h7E);
    wr(CADDR, 32'hFFFF_FF7E, 4'b0001);
    drain("rec_drain_timeout");
    check("rec_sb_empty", sb_q.size(), 32'd0);
    check("rec_drop", {24'h0, drop_cnt}, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
